div_32: RTL
===========

Name: div_32

Overview:
- Multi-cycle signed 32-bit divider. It is the inverse datapath of the combinational multiplier and implements the ALU DIV opcode (4'b1001), which the ALU currently leaves unimplemented.
- It sits beside the ALU. The control unit pulses start, waits for done, then latches the 64-bit result into HI/LO.
- Result format matches MUL's 64-bit output: remainder in [63:32] (HI) and quotient in [31:0] (LO).
- Uses restoring division, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand width. The result is 2*WIDTH. Only 32 is verified.

Ports:
- in_clk  input  1  system clock, rising edge
- in_reset  input  1  synchronous, active-high reset
- in_start  input  1  request pulse; sampled only in IDLE
- in_a  input  32  dividend, two's complement; sampled with accepted start
- in_b  input  32  divisor, two's complement; sampled with accepted start
- out_busy  output  1  high whenever state != IDLE
- out_done  output  1  one-cycle pulse when out_result is updated
- out_div_zero  output  1  divisor was zero for the last completed op; held with out_result
- out_result  output  64  {remainder, quotient}; held until the next completion

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is synchronous and active-high.
  - When in_reset is high at an edge: state=IDLE; out_busy=0, out_done=0, out_div_zero=0, out_result=64'h0; iteration counter=0.
  - Reset overrides everything, including mid-operation. An in-flight divide is discarded and produces no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If in_start=1 at edge E0: latch in_a and in_b, both signs, |a| and |b| as unsigned 32-bit (abs(0x80000000)=0x80000000), and zero_flag=(in_b==0).
  - Clear the partial remainder (33-bit) and counter, then go to RUN.
  - If in_start=0, stay in IDLE.
- RUN, one iteration per edge, 32 iterations (E1..E32), MSB of the dividend first:
  - Shift {rem, dvd} left by 1.
  - Compute trial = rem - |b|.
  - If trial >= 0: rem=trial and the new quotient LSB=1. Otherwise rem is unchanged and the LSB=0.
  - Counter increments. At counter==31 the transition goes to FIX.
- FIX (edge E33): write out_result and out_div_zero, then go to DONE.
  - Quotient is negated if sign_a XOR sign_b.
  - Remainder is negated if sign_a. Division truncates toward zero, remainder has the dividend's sign, and a == q*b + r.
  - Divide by zero (zero_flag): quotient=32'hFFFFFFFF, remainder=original in_a, out_div_zero=1. The iterations still run so latency is uniform; their datapath result is discarded.
  - Overflow: 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000 (wraps), remainder=0, out_div_zero=0. No trap.
- DONE: out_done=1 for exactly this cycle. Edge E34 returns to IDLE.
- Latency:
  - out_done is high during the cycle after E33, i.e. 34 cycles from the start cycle.
  - The earliest next accepted start is sampled at E35, the first IDLE cycle.
- Start handling:
  - in_start in RUN, FIX or DONE is ignored: not queued, no effect.
  - Holding in_start high continuously restarts an operation on each IDLE cycle using the current operand values.
- Operands: in_a and in_b may change freely after the accepting edge; internal copies are used.
- Output stability: out_result and out_div_zero change only at the FIX edge or on reset. They are stable through the next operation until its FIX edge.
- Implementation: registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then a=100 (0x64), b=7, start for one cycle:
  - out_busy=1 from E0+1.
  - out_done pulse exactly 34 cycles after start.
  - out_result=64'h00000002_0000000E, out_div_zero=0.
- Signed cases:
  - a=-100 (0xFFFFFF9C), b=7 -> 64'hFFFFFFFE_FFFFFFF2.
  - a=100, b=-7 -> 64'h00000002_FFFFFFF2.
  - a=-100, b=-7 -> 64'hFFFFFFFE_0000000E.
- Boundaries:
  - a=32'h80000000, b=32'hFFFFFFFF -> 64'h00000000_80000000.
  - a=0xFFFFFFFF, b=1 -> 64'h00000000_FFFFFFFF.
  - a=3, b=5 -> 64'h00000003_00000000.
- Divide by zero, a=5, b=0:
  - After the same 34-cycle latency: out_result=64'h00000005_FFFFFFFF, out_div_zero=1.
  - A following 6/3 gives out_div_zero=0 and result 64'h00000000_00000002.
- Start while busy:
  - Start 100/7, then pulse in_start with a=9, b=3 at cycle 10.
  - Result is 100/7 only, with a single out_done pulse.
  - Start asserted in the DONE cycle is ignored; start asserted the next cycle is accepted.
- Reset mid-operation:
  - Assert in_reset at cycle 15 of a run.
  - Next cycle: out_busy=0, out_done=0, out_result=0.
  - No done pulse follows.
  - A new 100/7 afterwards completes correctly with normal latency.

Source files
------------

// File: rtl/div_32_if.sv
// div_32_if: request/response bundle between the control unit and the divider.
//   in_start     - request pulse (master -> divider)
//   in_a, in_b   - dividend / divisor, two's complement (master -> divider)
//   out_busy     - divider not idle
//   out_done     - one-cycle pulse when out_result is updated
//   out_div_zero - last completed op had a zero divisor
//   out_result   - {remainder, quotient}, held until the next completion
interface div_32_if #(
   parameter int unsigned WIDTH = 32
);
   logic                   in_start;
   logic [WIDTH-1:0]       in_a;
   logic [WIDTH-1:0]       in_b;
   logic                   out_busy;
   logic                   out_done;
   logic                   out_div_zero;
   logic [2*WIDTH-1:0]     out_result;

   modport master (
      output in_start, in_a, in_b,
      input  out_busy, out_done, out_div_zero, out_result
   );

   modport slave (
      input  in_start, in_a, in_b,
      output out_busy, out_done, out_div_zero, out_result
   );
endinterface

// File: rtl/div_32.sv
// div_32: multi-cycle signed divider, restoring algorithm, one quotient bit
// per clock. Result layout matches the multiplier: {remainder, quotient}.
// Quotient truncates toward zero, remainder takes the dividend's sign.
// Divide by zero yields quotient all-ones, remainder = dividend, div_zero=1.
//   in_clk   - clock, rising edge
//   in_reset - synchronous, active-high reset
//   bus      - div_32_if slave (start/operands in, busy/done/result out)
module div_32 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic    in_clk,
   input  logic    in_reset,
   div_32_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [WIDTH-1:0]     dvd_q, dvd_d;    // |a| shifting out, quotient shifting in
   logic [WIDTH-1:0]     babs_q, babs_d;
   logic [WIDTH-1:0]     a_q, a_d;        // original dividend: sign and div-zero remainder
   logic                 sign_b_q, sign_b_d;
   logic                 zero_q, zero_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 dz_q, dz_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic [WIDTH:0]       shifted;
   logic                 ge;
   logic [WIDTH-1:0]     quot_fix, rem_fix;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      babs_d   = babs_q;
      a_d      = a_q;
      sign_b_d = sign_b_q;
      zero_d   = zero_q;
      dz_d     = dz_q;
      result_d = result_q;

      // Partial remainder is always < |b| <= 2^(WIDTH-1), so only the shifted
      // trial value needs the extra bit; the stored remainder fits in WIDTH.
      shifted  = {rem_q, dvd_q[WIDTH-1]};
      ge       = (shifted >= {1'b0, babs_q});
      quot_fix = (a_q[WIDTH-1] ^ sign_b_q) ? -dvd_q : dvd_q;
      rem_fix  = a_q[WIDTH-1] ? -rem_q : rem_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_start) begin
               a_d      = bus.in_a;
               sign_b_d = bus.in_b[WIDTH-1];
               dvd_d    = bus.in_a[WIDTH-1] ? -bus.in_a : bus.in_a;
               babs_d   = bus.in_b[WIDTH-1] ? -bus.in_b : bus.in_b;
               zero_d   = (bus.in_b == '0);
               rem_d    = '0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            rem_d = ge ? (shifted[WIDTH-1:0] - babs_q) : shifted[WIDTH-1:0];
            dvd_d = {dvd_q[WIDTH-2:0], ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = zero_q ? {a_q, {WIDTH{1'b1}}} : {rem_fix, quot_fix};
            dz_d     = zero_q;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status flags are registered from the next state so they line up
      // with the state they describe without any input-to-output path.
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge in_clk) begin
      if (in_reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         babs_q   <= '0;
         a_q      <= '0;
         sign_b_q <= 1'b0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         babs_q   <= babs_d;
         a_q      <= a_d;
         sign_b_q <= sign_b_d;
         zero_q   <= zero_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
         result_q <= result_d;
      end
   end

   assign bus.out_busy     = busy_q;
   assign bus.out_done     = done_q;
   assign bus.out_div_zero = dz_q;
   assign bus.out_result   = result_q;
endmodule
